ctl_fsm_mc: RTL and testbench

- Parametrised successor to the pipeline control FSM for the mips789 core.
- Decodes the ID-stage command into per-cycle clear/hold strobes for the ID->RA and RA->EXEC pipeline registers, and a PC pre-control code.
- New over the previous generation: separate MUL and DIV latencies, IRQ_N maskable interrupt lines with fixed priority and a latched vector ID, a busy flag, and interrupts accepted from NOI as well as IDLE.

---
 rtl/ctl_fsm_mc.sv | 187 ++++++++++++++++++
 tb/tb_ctl_fsm_mc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_fsm_mc.sv
`default_nettype none
// ctl_fsm_mc: mips789 pipeline control FSM with MUL/DIV latencies, masked prioritised IRQs and busy flag (rev 1.0).
// Optional stall_cnt output enabled by defining CTL_FSM_STALL_CNT_EN.
module ctl_fsm_mc #(
  parameter int IRQ_N   = 4,
  parameter int IRQ_IDW = 2,
  parameter int MUL_LAT = 33,
  parameter int DIV_LAT = 35,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic [2:0]         id_cmd,
  input  logic [IRQ_N-1:0]   irq,
  input  logic [IRQ_N-1:0]   irq_mask,
  output logic               iack,
  output logic [IRQ_IDW-1:0] irq_id,
  output logic               busy,
  output logic               zz_is_nop,
  output logic               id2ra_ins_clr,
  output logic               id2ra_ins_cls,
  output logic               id2ra_ctl_clr,
  output logic               id2ra_ctl_cls,
  output logic               ra2exec_ctl_clr,
  output logic [3:0]         pc_prectl
`ifdef CTL_FSM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [2:0] FSM_NOI = 3'b000;
  localparam logic [2:0] FSM_CUR = 3'b001;
  localparam logic [2:0] FSM_MUL = 3'b010;
  localparam logic [2:0] FSM_LD  = 3'b011;
  localparam logic [2:0] FSM_RET = 3'b100;
  localparam logic [2:0] FSM_DIV = 3'b110;

  localparam logic [3:0] PC_IGN = 4'b0001;
  localparam logic [3:0] PC_KEP = 4'b0010;
  localparam logic [3:0] PC_IRQ = 4'b0100;
  localparam logic [3:0] PC_RST = 4'b1000;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_NOI  = 3'd2,
    S_CUR  = 3'd3,
    S_LD   = 3'd4,
    S_MUL  = 3'd5,
    S_IRQ  = 3'd6,
    S_RET  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               iack_q;
  logic [IRQ_IDW-1:0] irq_id_q, irq_id_d;
  logic [IRQ_N-1:0]   irq_act;
  logic [IRQ_IDW-1:0] irq_sel;
  logic               pend;

  // Mask applies combinationally; a line in service blocks further entries.
  assign irq_act = irq & ~irq_mask;
  assign pend    = (|irq_act) & ~iack_q;

  // Scan downwards so the lowest active index wins.
  always_comb begin
    irq_sel = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_sel = IRQ_IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      iack_q   <= 1'b0;
      irq_id_q <= '0;
    end else if (!pause) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iack_q   <= iack;
      irq_id_q <= irq_id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_IDLE, S_NOI: begin
        if (pend) begin
          state_d  = S_IRQ;
          irq_id_d = irq_sel;
        end else begin
          case (id_cmd)
            FSM_NOI: state_d = S_NOI;
            FSM_CUR: state_d = S_CUR;
            FSM_MUL: begin
              state_d = S_MUL;
              cnt_d   = MUL_LD;
            end
            FSM_DIV: begin
              state_d = S_MUL;
              cnt_d   = DIV_LD;
            end
            FSM_LD:  state_d = S_LD;
            FSM_RET: state_d = S_RET;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CUR:                      state_d = S_NOI;
      S_LD, S_RET, S_IRQ, S_RST:  state_d = S_IDLE;
      S_MUL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default:                    state_d = S_RST;
    endcase
  end

  always_comb begin
    id2ra_ins_clr   = 1'b1;
    id2ra_ins_cls   = 1'b0;
    id2ra_ctl_clr   = 1'b1;
    id2ra_ctl_cls   = 1'b0;
    ra2exec_ctl_clr = 1'b1;
    zz_is_nop       = 1'b1;
    pc_prectl       = PC_RST;
    iack            = iack_q;
    case (state_q)
      S_IDLE, S_NOI, S_RET: begin
        id2ra_ins_clr   = 1'b0;
        id2ra_ctl_clr   = 1'b0;
        ra2exec_ctl_clr = 1'b0;
        zz_is_nop       = 1'b0;
        pc_prectl       = PC_IGN;
        if (state_q == S_RET) iack = 1'b0;
      end
      S_MUL, S_LD: begin
        ra2exec_ctl_clr = 1'b0;
        zz_is_nop       = 1'b0;
        pc_prectl       = PC_KEP;
      end
      S_CUR: begin
        id2ra_ins_clr   = 1'b0;
        id2ra_ins_cls   = 1'b1;
        id2ra_ctl_clr   = 1'b0;
        id2ra_ctl_cls   = 1'b1;
        pc_prectl       = PC_KEP;
      end
      S_IRQ: begin
        zz_is_nop       = 1'b0;
        pc_prectl       = PC_IRQ;
        iack            = 1'b1;
      end
      default: ;
    endcase
  end

  assign irq_id = irq_id_q;
  assign busy   = (state_q == S_MUL);

`ifdef CTL_FSM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (!pause && (pc_prectl == PC_KEP) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctl_fsm_mc.sv
`default_nettype none
// Bench for ctl_fsm_mc: default-latency and short-latency instances, scoreboard-driven checks.
module tb_ctl_fsm_mc;

  localparam logic [2:0] FSM_NOI = 3'b000;
  localparam logic [2:0] FSM_CUR = 3'b001;
  localparam logic [2:0] FSM_MUL = 3'b010;
  localparam logic [2:0] FSM_LD  = 3'b011;
  localparam logic [2:0] FSM_RET = 3'b100;
  localparam logic [2:0] FSM_DIV = 3'b110;

  localparam logic [3:0] PC_IGN = 4'b0001;
  localparam logic [3:0] PC_KEP = 4'b0010;
  localparam logic [3:0] PC_IRQ = 4'b0100;
  localparam logic [3:0] PC_RST = 4'b1000;

  // {ins_clr, ins_cls, ctl_clr, ctl_cls, ra2exec_clr, zz_is_nop, pc_prectl}
  localparam logic [9:0] RST_V  = {6'b101011, PC_RST};
  localparam logic [9:0] IDLE_V = {6'b000000, PC_IGN};
  localparam logic [9:0] KEP_V  = {6'b101000, PC_KEP};
  localparam logic [9:0] CUR_V  = {6'b010111, PC_KEP};
  localparam logic [9:0] IRQ_V  = {6'b101010, PC_IRQ};

  logic       clk, rst_n, pause;
  logic [2:0] id_cmd, id_cmd_s;
  logic [3:0] irq, irq_mask, irq_s, mask_s;

  logic       iack, busy, zz, ins_clr, ins_cls, ctl_clr, ctl_cls, ra2exec;
  logic [1:0] irq_id;
  logic [3:0] pc;
  logic       iack_s, busy_s, zz_s, ins_clr_s, ins_cls_s, ctl_clr_s, ctl_cls_s, ra2exec_s;
  logic [1:0] irq_id_s;
  logic [3:0] pc_s;
`ifdef CTL_FSM_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_s;
`endif
  logic [9:0] strb;

  assign strb = {ins_clr, ins_cls, ctl_clr, ctl_cls, ra2exec, zz, pc};

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  ctl_fsm_mc dut (
    .clk(clk), .rst(rst_n), .pause(pause), .id_cmd(id_cmd), .irq(irq), .irq_mask(irq_mask),
    .iack(iack), .irq_id(irq_id), .busy(busy), .zz_is_nop(zz),
    .id2ra_ins_clr(ins_clr), .id2ra_ins_cls(ins_cls), .id2ra_ctl_clr(ctl_clr),
    .id2ra_ctl_cls(ctl_cls), .ra2exec_ctl_clr(ra2exec), .pc_prectl(pc)
`ifdef CTL_FSM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  ctl_fsm_mc #(.IRQ_N(4), .IRQ_IDW(2), .MUL_LAT(4), .DIV_LAT(7), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst_n), .pause(pause), .id_cmd(id_cmd_s), .irq(irq_s), .irq_mask(mask_s),
    .iack(iack_s), .irq_id(irq_id_s), .busy(busy_s), .zz_is_nop(zz_s),
    .id2ra_ins_clr(ins_clr_s), .id2ra_ins_cls(ins_cls_s), .id2ra_ctl_clr(ctl_clr_s),
    .id2ra_ctl_cls(ctl_cls_s), .ra2exec_ctl_clr(ra2exec_s), .pc_prectl(pc_s)
`ifdef CTL_FSM_STALL_CNT_EN
    , .stall_cnt(stall_cnt_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a MUL/DIV command and counts cycles spent busy; optional 3-cycle pause window.
  task automatic run_mul(input bit sel, input logic [2:0] cmd, input int pause_at,
                         output int cyc, output int unp, output int bad);
    if (sel) id_cmd_s = cmd;
    else     id_cmd   = cmd;
    step();
    id_cmd   = FSM_NOI;
    id_cmd_s = FSM_NOI;
    cyc = 0; unp = 0; bad = 0;
    while ((sel ? busy_s : busy) && cyc < 200) begin
      if ((sel ? pc_s : pc) !== PC_KEP) bad++;
      pause = (pause_at >= 0) && (cyc >= pause_at) && (cyc < pause_at + 3);
      if (!pause) unp++;
      cyc++;
      step();
    end
    pause = 1'b0;
  endtask

  task automatic do_ret();
    irq    = '0;
    id_cmd = FSM_NOI;
    step();
    id_cmd = FSM_RET;
    step();
    id_cmd = FSM_NOI;
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    exp_q.push_back(32'(RST_V));
    n_checks++; e = exp_q.pop_front();
    if (32'(strb) !== e) begin n_fail++; $display("FAIL reset_strobe: got %h expected %h", strb, e); end
    n_checks++;
    if ({iack, irq_id, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {iack, irq_id, busy}); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (strb !== RST_V) begin n_fail++; $display("FAIL reset_hold_cycle: got %h expected %h", strb, RST_V); end
    step();
    n_checks++;
    if (strb !== IDLE_V) begin n_fail++; $display("FAIL reset_to_idle: got %h expected %h", strb, IDLE_V); end
    // Reset again part-way through a multiply (counter at 20).
    id_cmd = FSM_MUL;
    step();
    id_cmd = FSM_NOI;
    repeat (12) step();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({strb, busy, iack} !== {RST_V, 2'b00}) begin
      n_fail++; $display("FAIL reset_mid_mul: got %h expected %h", {strb, busy, iack}, {RST_V, 2'b00});
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({strb, busy} !== {IDLE_V, 1'b0}) begin n_fail++; $display("FAIL reset_mid_mul_release: got %h expected %h", {strb, busy}, {IDLE_V, 1'b0}); end
  endtask

  task automatic test_multiply();
    int cyc, unp, bad;
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd0);
    run_mul(1'b0, FSM_MUL, -1, cyc, unp, bad);
    n_checks++; e = exp_q.pop_front();
    if (32'(unp) !== e) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", unp, e); end
    n_checks++; e = exp_q.pop_front();
    if (32'(bad) !== e) begin n_fail++; $display("FAIL mul_pc_kep: got %0d bad cycles expected %0d", bad, e); end
    n_checks++;
    if (strb !== IDLE_V) begin n_fail++; $display("FAIL mul_exit_idle: got %h expected %h", strb, IDLE_V); end
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd36);
    run_mul(1'b0, FSM_MUL, 10, cyc, unp, bad);
    n_checks++; e = exp_q.pop_front();
    if (32'(unp) !== e) begin n_fail++; $display("FAIL mul_pause_unpaused: got %0d expected %0d", unp, e); end
    n_checks++; e = exp_q.pop_front();
    if (32'(cyc) !== e) begin n_fail++; $display("FAIL mul_pause_total: got %0d expected %0d", cyc, e); end
  endtask

  task automatic test_divide();
    int cyc, unp, bad;
    exp_q.push_back(32'd35);
    run_mul(1'b0, FSM_DIV, -1, cyc, unp, bad);
    n_checks++; e = exp_q.pop_front();
    if (32'(unp) !== e) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", unp, e); end
    exp_q.push_back(32'd7);
    run_mul(1'b1, FSM_DIV, -1, cyc, unp, bad);
    n_checks++; e = exp_q.pop_front();
    if (32'(unp) !== e) begin n_fail++; $display("FAIL div_short_latency: got %0d expected %0d", unp, e); end
    exp_q.push_back(32'd4);
    run_mul(1'b1, FSM_MUL, -1, cyc, unp, bad);
    n_checks++; e = exp_q.pop_front();
    if (32'(unp) !== e) begin n_fail++; $display("FAIL mul_short_latency: got %0d expected %0d", unp, e); end
  endtask

  task automatic test_irq_priority();
    id_cmd = FSM_NOI;
    step();
    irq      = 4'b1010;
    irq_mask = 4'b0010;
    id_cmd   = FSM_CUR;
    exp_q.push_back({19'd0, IRQ_V, 1'b1, 2'd3});
    step();
    n_checks++; e = exp_q.pop_front();
    if ({19'd0, strb, iack, irq_id} !== e) begin n_fail++; $display("FAIL irq_enter: got %h expected %h", {strb, iack, irq_id}, e); end
    id_cmd   = FSM_NOI;
    irq      = 4'b0001;
    irq_mask = 4'b0000;
    exp_q.push_back({19'd0, IDLE_V, 1'b1, 2'd3});
    exp_q.push_back({19'd0, IDLE_V, 1'b1, 2'd3});
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; e = exp_q.pop_front();
      if ({19'd0, strb, iack, irq_id} !== e) begin n_fail++; $display("FAIL irq_held_%0d: got %h expected %h", k, {strb, iack, irq_id}, e); end
    end
    id_cmd = FSM_RET;
    exp_q.push_back({19'd0, IDLE_V, 1'b0, 2'd3});
    step();
    n_checks++; e = exp_q.pop_front();
    if ({19'd0, strb, iack, irq_id} !== e) begin n_fail++; $display("FAIL irq_ret: got %h expected %h", {strb, iack, irq_id}, e); end
    id_cmd = FSM_NOI;
    step();
    exp_q.push_back({19'd0, IRQ_V, 1'b1, 2'd0});
    step();
    n_checks++; e = exp_q.pop_front();
    if ({19'd0, strb, iack, irq_id} !== e) begin n_fail++; $display("FAIL irq_second: got %h expected %h", {strb, iack, irq_id}, e); end
    do_ret();
    n_checks++;
    if (iack !== 1'b0) begin n_fail++; $display("FAIL irq_cleanup_iack: got %b expected 0", iack); end
  endtask

  task automatic test_blocked_irq();
    int cyc, bad;
    id_cmd = FSM_MUL;
    step();
    id_cmd = FSM_NOI;
    irq    = 4'b0100;
    cyc = 0; bad = 0;
    while (busy && cyc < 200) begin
      if (pc === PC_IRQ || iack !== 1'b0) bad++;
      cyc++;
      step();
    end
    n_checks++;
    if ({cyc, bad} !== {32'd33, 32'd0}) begin n_fail++; $display("FAIL blocked_during_mul: got cyc=%0d bad=%0d expected cyc=33 bad=0", cyc, bad); end
    n_checks++;
    if ({strb, iack} !== {IDLE_V, 1'b0}) begin n_fail++; $display("FAIL blocked_exit_idle: got %h expected %h", {strb, iack}, {IDLE_V, 1'b0}); end
    exp_q.push_back({19'd0, IRQ_V, 1'b1, 2'd2});
    step();
    n_checks++; e = exp_q.pop_front();
    if ({19'd0, strb, iack, irq_id} !== e) begin n_fail++; $display("FAIL blocked_then_irq: got %h expected %h", {strb, iack, irq_id}, e); end
    do_ret();
    // Mask acts in the same cycle it is applied.
    irq      = 4'b0100;
    irq_mask = 4'b0100;
    step();
    n_checks++;
    if ({strb, iack} !== {IDLE_V, 1'b0}) begin n_fail++; $display("FAIL mask_blocks: got %h expected %h", {strb, iack}, {IDLE_V, 1'b0}); end
    irq_mask = 4'b0000;
    step();
    n_checks++;
    if ({strb, irq_id} !== {IRQ_V, 2'd2}) begin n_fail++; $display("FAIL mask_release: got %h expected %h", {strb, irq_id}, {IRQ_V, 2'd2}); end
    do_ret();
  endtask

  task automatic test_cur_ld();
`ifdef CTL_FSM_STALL_CNT_EN
    logic [31:0] sc0;
    sc0 = stall_cnt;
`endif
    id_cmd = FSM_CUR;
    exp_q.push_back(32'(CUR_V));
    exp_q.push_back(32'(IDLE_V));
    step();
    n_checks++; e = exp_q.pop_front();
    if (32'(strb) !== e) begin n_fail++; $display("FAIL cur_strobe: got %h expected %h", strb, e); end
    id_cmd = FSM_NOI;
    step();
    n_checks++; e = exp_q.pop_front();
    if (32'(strb) !== e) begin n_fail++; $display("FAIL cur_to_noi: got %h expected %h", strb, e); end
`ifdef CTL_FSM_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== sc0 + 32'd1) begin n_fail++; $display("FAIL stall_cnt_inc: got %0d expected %0d", stall_cnt, sc0 + 32'd1); end
`endif
    id_cmd = FSM_LD;
    exp_q.push_back(32'(KEP_V));
    step();
    n_checks++; e = exp_q.pop_front();
    if (32'(strb) !== e) begin n_fail++; $display("FAIL ld_strobe: got %h expected %h", strb, e); end
    id_cmd = FSM_RET;
    step();
    step();
    n_checks++;
    if ({strb, iack} !== {IDLE_V, 1'b0}) begin n_fail++; $display("FAIL ret_without_irq: got %h expected %h", {strb, iack}, {IDLE_V, 1'b0}); end
    id_cmd = FSM_NOI;
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    pause    = 1'b0;
    id_cmd   = FSM_NOI;
    id_cmd_s = FSM_NOI;
    irq      = '0;
    irq_mask = '0;
    irq_s    = '0;
    mask_s   = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_irq_priority();
    test_blocked_irq();
    test_cur_ld();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
